// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down modulus counter.
// Mode selects what happens at a limit; direction encodes up_dn.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } cnt_mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter_if.sv
// Bundle of every updown_mod_counter signal except clk.
// Used when a counter is wired through a block boundary.
interface updown_counter_if #(
  parameter int WIDTH = 8
) ();

  logic             reset_n;
  logic             enable;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             up_dn;
  logic             mode;
  logic [WIDTH-1:0] max_val;
  logic             ovf_clr;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_zero;
  logic             tc_pulse;
  logic             ovf_sticky;

  modport ctrl (
    output reset_n, enable, clear, load, load_val, up_dn, mode, max_val, ovf_clr,
    input  count, at_max, at_zero, tc_pulse, ovf_sticky
  );

  modport cnt (
    input  reset_n, enable, clear, load, load_val, up_dn, mode, max_val, ovf_clr,
    output count, at_max, at_zero, tc_pulse, ovf_sticky
  );

endinterface

// File: rtl/counter_next_calc.sv
// Combinational step for one enabled count: next value and boundary event.
// The >= test on the up path pulls a count left above a lowered max_val back in.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] max_val,
  input  logic             up_dn,
  input  cnt_mode_e        mode,
  output logic [WIDTH-1:0] next_count,
  output logic             evt
);

  always_comb begin
    next_count = count;
    evt        = 1'b0;
    if (up_dn == DIR_UP) begin
      if (count < max_val) begin
        next_count = count + WIDTH'(1);
      end else begin
        evt        = 1'b1;
        next_count = (mode == MODE_SAT) ? max_val : '0;
      end
    end else begin
      if (count != '0) begin
        next_count = count - WIDTH'(1);
      end else begin
        evt        = 1'b1;
        next_count = (mode == MODE_SAT) ? '0 : max_val;
      end
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter with runtime modulus, load, clear, wrap/saturate modes,
// a one-cycle boundary pulse and a sticky overflow flag.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic             mode,
  input  logic [WIDTH-1:0] max_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_zero,
  output logic             tc_pulse,
  output logic             ovf_sticky
);

  logic [WIDTH-1:0] step_count;
  logic             step_evt;
  logic [WIDTH-1:0] load_clip;
  logic             evt_taken;

  counter_next_calc #(
    .WIDTH(WIDTH)
  ) u_next (
    .count      (count),
    .max_val    (max_val),
    .up_dn      (up_dn),
    .mode       (cnt_mode_e'(mode)),
    .next_count (step_count),
    .evt        (step_evt)
  );

  // A clear or load on the same edge overrides the step, so its event is dropped.
  always_comb begin
    load_clip = (load_val > max_val) ? max_val : load_val;
    evt_taken = enable & ~clear & ~load & step_evt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count      <= WIDTH'(RESET_VAL);
      tc_pulse   <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (load) begin
        count <= load_clip;
      end else if (enable) begin
        count <= step_count;
      end
      tc_pulse <= evt_taken;
      if (evt_taken) begin
        ovf_sticky <= 1'b1;
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

  assign at_max  = (count >= max_val);
  assign at_zero = (count == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomised and directed bench for updown_mod_counter (WIDTH=4, RESET_VAL=3)
// against an integer reference model of the counting rules.
module tb_updown_mod_counter;

  localparam int W  = 4;
  localparam int RV = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable, clear, load, up_dn, mode, ovf_clr;
  logic [W-1:0] load_val, max_val;
  logic [W-1:0] count;
  logic         at_max, at_zero, tc_pulse, ovf_sticky;

  updown_mod_counter #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .clear      (clear),
    .load       (load),
    .load_val   (load_val),
    .up_dn      (up_dn),
    .mode       (mode),
    .max_val    (max_val),
    .ovf_clr    (ovf_clr),
    .count      (count),
    .at_max     (at_max),
    .at_zero    (at_zero),
    .tc_pulse   (tc_pulse),
    .ovf_sticky (ovf_sticky)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  int m_count;
  int m_tc;
  int m_ovf;

  // scoreboard: {count, tc_pulse, ovf_sticky} expected after each edge
  logic [W+1:0] exp_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int tc_seen  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = RV;
    m_tc    = 0;
    m_ovf   = 0;
  endtask

  // Counting rules with plain integers: range is 0..mx inclusive.
  task automatic model_edge(input int en, clr, ld, lv, ud, md, mx, oc);
    int ev;
    ev = 0;
    if (clr != 0) m_count = 0;
    else if (ld != 0) m_count = (lv < mx) ? lv : mx;
    else if (en != 0) begin
      if (ud != 0) begin
        if (m_count >= mx) begin ev = 1; m_count = (md != 0) ? mx : 0; end
        else m_count = m_count + 1;
      end else begin
        if (m_count == 0) begin ev = 1; m_count = (md != 0) ? 0 : mx; end
        else m_count = m_count - 1;
      end
    end
    m_tc = ev;
    if (ev != 0) m_ovf = 1;
    else if (oc != 0) m_ovf = 0;
  endtask

  task automatic check_outputs(input string tag);
    logic [W+1:0] e;
    int ec;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
      return;
    end
    e  = exp_q.pop_front();
    ec = int'(e[W+1:2]);
    check_eq({tag, "_count"}, 32'(count), 32'(ec));
    check_eq({tag, "_tc"}, 32'(tc_pulse), 32'(e[1]));
    check_eq({tag, "_ovf"}, 32'(ovf_sticky), 32'(e[0]));
    check_eq({tag, "_at_max"}, 32'(at_max), (ec >= int'(max_val)) ? 32'd1 : 32'd0);
    check_eq({tag, "_at_zero"}, 32'(at_zero), (ec == 0) ? 32'd1 : 32'd0);
    if (tc_pulse === 1'b1) tc_seen++;
  endtask

  // driver: apply inputs, predict, clock, compare 1 time unit after the edge
  task automatic step(input string tag, input logic en, clr, ld, input logic [W-1:0] lv,
                      input logic ud, md, input logic [W-1:0] mx, input logic oc);
    enable = en; clear = clr; load = ld; load_val = lv;
    up_dn = ud; mode = md; max_val = mx; ovf_clr = oc;
    model_edge(int'(en), int'(clr), int'(ld), int'(lv), int'(ud), int'(md), int'(mx), int'(oc));
    exp_q.push_back({W'(m_count), m_tc[0], m_ovf[0]});
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_clear(input logic [W-1:0] mx);
    step("clr", 1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, mx, 1'b1);
  endtask

  // async reset asserted between edges, released before the next edge
  task automatic mid_reset(input string tag);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq({tag, "_count"}, 32'(count), 32'(RV));
    check_eq({tag, "_tc"}, 32'(tc_pulse), 32'd0);
    check_eq({tag, "_ovf"}, 32'(ovf_sticky), 32'd0);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 0; clear = 0; load = 0; load_val = 0;
    up_dn = 1; mode = 0; max_val = 4'd9; ovf_clr = 0;
    model_reset();
    #12;
    check_eq("reset_count", 32'(count), 32'(RV));
    check_eq("reset_tc", 32'(tc_pulse), 32'd0);
    check_eq("reset_ovf", 32'(ovf_sticky), 32'd0);
    reset_n = 1'b1;

    // 1: reset mid-count at 5
    step("t1_load", 1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 4'd9, 1'b0);
    check_eq("t1_pre", 32'(count), 32'd5);
    mid_reset("t1_rst");

    // 2: wrap up from 0, 12 steps
    idle_clear(4'd9);
    tc_seen = 0;
    for (int i = 0; i < 12; i++)
      step("t2", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd9, 1'b0);
    check_eq("t2_final", 32'(count), 32'd2);
    check_eq("t2_tc_cnt", 32'(tc_seen), 32'd1);
    check_eq("t2_ovf", 32'(ovf_sticky), 32'd1);

    // 3: sat down from 2, tc on two consecutive cycles
    step("t3_load", 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 4'd9, 1'b1);
    tc_seen = 0;
    for (int i = 0; i < 4; i++)
      step("t3", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0);
    check_eq("t3_final", 32'(count), 32'd0);
    check_eq("t3_tc_cnt", 32'(tc_seen), 32'd2);
    check_eq("t3_tc_last", 32'(tc_pulse), 32'd1);

    // 4: load clipped to max_val, clear beats load
    step("t4_load", 1'b0, 1'b0, 1'b1, 4'd13, 1'b1, 1'b0, 4'd9, 1'b0);
    check_eq("t4_clip", 32'(count), 32'd9);
    step("t4_clrld", 1'b1, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 4'd9, 1'b0);
    check_eq("t4_clr", 32'(count), 32'd0);

    // 5: max_val lowered below count
    step("t5_load", 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 4'd9, 1'b1);
    step("t5_up", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd6, 1'b0);
    check_eq("t5_up_cnt", 32'(count), 32'd0);
    check_eq("t5_up_tc", 32'(tc_pulse), 32'd1);
    step("t5_reload", 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 4'd9, 1'b0);
    step("t5_dn", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd6, 1'b0);
    check_eq("t5_dn_cnt", 32'(count), 32'd8);
    check_eq("t5_dn_tc", 32'(tc_pulse), 32'd0);

    // 6: set wins over ovf_clr, then clear alone
    step("t6_load", 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 4'd9, 1'b1);
    step("t6_both", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9, 1'b1);
    check_eq("t6_ovf_set", 32'(ovf_sticky), 32'd1);
    step("t6_clr", 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd9, 1'b1);
    check_eq("t6_ovf_clr", 32'(ovf_sticky), 32'd0);

    // max_val = 0: every step is an event, count stays 0
    idle_clear(4'd0);
    step("mx0_up", 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0);
    step("mx0_dn", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    step("mx0_sat", 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0);

    // event suppressed by a same-edge load
    step("sup_load", 1'b0, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 4'd9, 1'b1);
    step("sup_ld_evt", 1'b1, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 4'd9, 1'b0);

    // random traffic
    begin
      logic [W-1:0] mx;
      mx = 4'd9;
      for (int i = 0; i < 800; i++) begin
        if ($urandom_range(15, 0) == 0) mx = W'($urandom_range(15, 0));
        step("rnd",
             ($urandom_range(9, 0) < 8),
             ($urandom_range(19, 0) == 0),
             ($urandom_range(15, 0) == 0),
             W'($urandom_range(15, 0)),
             1'($urandom_range(1, 0)),
             1'($urandom_range(1, 0)),
             mx,
             ($urandom_range(7, 0) == 0));
        if ($urandom_range(99, 0) == 0) mid_reset("rnd_rst");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
